fetch_ifid: RTL and testbench

Instruction-fetch stage with the IF/ID pipeline register for the LEGv8 pipeline. It holds the PC and fetches 32-bit instructions over a request/acknowledge memory port. It presents each instruction with its PC to decode, where `signext` and the register file consume `instr_D`. It also handles decode stalls and taken-branch redirects (CBZ/B) coming back from downstream.

---
 rtl/fetch_ifid_if.sv | 26 ++
 rtl/fetch_ifid.sv | 141 ++++++++++++++
 tb/tb_fetch_ifid.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fetch_ifid_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack port, decode-side
// stall/redirect inputs and the IF/ID register outputs.
interface fetch_ifid_if #(
  parameter int N = 64
);
  logic          imem_req;
  logic [N-1:0]  imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          stall_D;
  logic          PCSrc_D;
  logic [N-1:0]  PCBranch_D;
  logic [31:0]   instr_D;
  logic [N-1:0]  pc_D;
  logic          valid_D;

  modport master (
    output imem_req, imem_addr, instr_D, pc_D, valid_D,
    input  imem_ack, imem_rdata, stall_D, PCSrc_D, PCBranch_D
  );

  modport slave (
    input  imem_req, imem_addr, instr_D, pc_D, valid_D,
    output imem_ack, imem_rdata, stall_D, PCSrc_D, PCBranch_D
  );
endinterface

// File: rtl/fetch_ifid.sv
// LEGv8 instruction fetch with IF/ID register, one-entry skid buffer for
// stall/ack collisions and a DROP state that drains requests made stale by a redirect.
module fetch_ifid #(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset,
  fetch_ifid_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_pc, w_pc_nxt;
  logic [N-1:0]  r_addr_q, w_addr_nxt;
  logic [31:0]   r_instr, w_instr_nxt;
  logic [N-1:0]  r_pc_D, w_pc_D_nxt;
  logic          r_valid, w_valid_nxt;
  logic [31:0]   r_skid_instr, w_skid_instr_nxt;
  logic [N-1:0]  r_skid_pc, w_skid_pc_nxt;
  logic [N-1:0]  w_target;
  logic [N-1:0]  w_addr_inc;

  // Branch targets are word aligned by construction; low bits are forced to zero.
  assign w_target   = {bus.PCBranch_D[N-1:2], 2'b00};
  assign w_addr_inc = r_addr_q + N'(4);

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_addr_nxt       = r_addr_q;
    w_instr_nxt      = r_instr;
    w_pc_D_nxt       = r_pc_D;
    w_valid_nxt      = r_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;

    unique case (r_state)
      FETCH: begin
        if (bus.PCSrc_D) begin
          w_instr_nxt = '0;
          w_valid_nxt = 1'b0;
          w_pc_nxt    = w_target;
          if (bus.imem_ack) begin
            w_addr_nxt = w_target;
          end else begin
            w_state_nxt = DROP;
          end
        end else if (bus.imem_ack) begin
          w_pc_nxt = w_addr_inc;
          if (!bus.stall_D) begin
            w_instr_nxt = bus.imem_rdata;
            w_pc_D_nxt  = r_addr_q;
            w_valid_nxt = 1'b1;
            w_addr_nxt  = w_addr_inc;
          end else begin
            w_skid_instr_nxt = bus.imem_rdata;
            w_skid_pc_nxt    = r_addr_q;
            w_state_nxt      = HOLD;
          end
        end else if (!bus.stall_D) begin
          w_instr_nxt = '0;
          w_valid_nxt = 1'b0;
        end
      end

      HOLD: begin
        if (bus.PCSrc_D) begin
          w_instr_nxt = '0;
          w_valid_nxt = 1'b0;
          w_pc_nxt    = w_target;
          w_addr_nxt  = w_target;
          w_state_nxt = FETCH;
        end else if (!bus.stall_D) begin
          w_instr_nxt = r_skid_instr;
          w_pc_D_nxt  = r_skid_pc;
          w_valid_nxt = 1'b1;
          w_addr_nxt  = r_pc;
          w_state_nxt = FETCH;
        end
      end

      DROP: begin
        // The stale request stays on the bus until memory acknowledges it.
        if (bus.PCSrc_D) begin
          w_instr_nxt = '0;
          w_valid_nxt = 1'b0;
          w_pc_nxt    = w_target;
        end else begin
          if (bus.imem_ack) begin
            w_addr_nxt  = r_pc;
            w_state_nxt = FETCH;
          end
          if (!bus.stall_D) begin
            w_instr_nxt = '0;
            w_valid_nxt = 1'b0;
          end
        end
      end

      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_addr_q <= RESET_PC;
      r_instr  <= '0;
      r_pc_D   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_addr_q <= w_addr_nxt;
      r_instr  <= w_instr_nxt;
      r_pc_D   <= w_pc_D_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_skid_instr <= w_skid_instr_nxt;
    r_skid_pc    <= w_skid_pc_nxt;
  end

  assign bus.imem_req  = reset && (r_state != HOLD);
  assign bus.imem_addr = r_addr_q;
  assign bus.instr_D   = r_instr;
  assign bus.pc_D      = r_pc_D;
  assign bus.valid_D   = r_valid;

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed cycle-by-cycle bench for fetch_ifid: each record gives this cycle's
// inputs, the expected request before the edge and the IF/ID contents after it.
module tb_fetch_ifid;

  localparam int N = 64;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fetch_ifid_if #(.N(N)) bus ();

  fetch_ifid #(.N(N), .RESET_PC('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          ack;
    logic [31:0]   rdata;
    logic          stall;
    logic          pcsrc;
    logic [N-1:0]  tgt;
    logic          exp_req;
    logic [N-1:0]  exp_addr;
    logic [31:0]   exp_instr;
    logic [N-1:0]  exp_pc;
    logic          exp_valid;
    logic          chk_pc;
  } vec_t;

  function automatic vec_t mk(logic rst_n, logic ack, logic [31:0] rdata, logic stall,
                              logic pcsrc, logic [N-1:0] tgt, logic exp_req,
                              logic [N-1:0] exp_addr, logic [31:0] exp_instr,
                              logic [N-1:0] exp_pc, logic exp_valid, logic chk_pc);
    vec_t v;
    v.rst_n = rst_n; v.ack = ack; v.rdata = rdata; v.stall = stall;
    v.pcsrc = pcsrc; v.tgt = tgt; v.exp_req = exp_req; v.exp_addr = exp_addr;
    v.exp_instr = exp_instr; v.exp_pc = exp_pc; v.exp_valid = exp_valid;
    v.chk_pc = chk_pc;
    return v;
  endfunction

  function automatic logic [31:0] word(logic [N-1:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(string name, int idx, logic [N-1:0] act, logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    @(negedge clk);
    reset          = v.rst_n;
    bus.imem_ack   = v.ack;
    bus.imem_rdata = v.rdata;
    bus.stall_D    = v.stall;
    bus.PCSrc_D    = v.pcsrc;
    bus.PCBranch_D = v.tgt;
    #1;
    chk("imem_req", idx, N'(bus.imem_req), N'(v.exp_req));
    if (v.exp_req) chk("imem_addr", idx, bus.imem_addr, v.exp_addr);
    @(posedge clk);
    #1;
    chk("instr_D", idx, N'(bus.instr_D), N'(v.exp_instr));
    chk("valid_D", idx, N'(bus.valid_D), N'(v.exp_valid));
    if (v.chk_pc) chk("pc_D", idx, bus.pc_D, v.exp_pc);
  endtask

  localparam logic [N-1:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  vec_t vecs[31];

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.stall_D = 1'b0;
    bus.PCSrc_D = 1'b0; bus.PCBranch_D = '0;

    // reset, then zero-wait sequential fetch
    vecs[0]  = mk(0, 0, 32'h0,         0, 0, 64'h0,   0, 64'h0,   32'h0,         64'h0,   0, 1);
    vecs[1]  = mk(1, 1, 32'hC0DE_0000, 0, 0, 64'h0,   1, 64'h0,   32'hC0DE_0000, 64'h0,   1, 1);
    vecs[2]  = mk(1, 1, 32'hC0DE_0004, 0, 0, 64'h0,   1, 64'h4,   32'hC0DE_0004, 64'h4,   1, 1);
    vecs[3]  = mk(1, 1, 32'hC0DE_0008, 0, 0, 64'h0,   1, 64'h8,   32'hC0DE_0008, 64'h8,   1, 1);
    vecs[4]  = mk(1, 1, 32'hC0DE_000C, 0, 0, 64'h0,   1, 64'hC,   32'hC0DE_000C, 64'hC,   1, 1);
    // three wait states on PC 0x10
    vecs[5]  = mk(1, 0, 32'h0,         0, 0, 64'h0,   1, 64'h10,  32'h0,         64'h0,   0, 0);
    vecs[6]  = mk(1, 0, 32'h0,         0, 0, 64'h0,   1, 64'h10,  32'h0,         64'h0,   0, 0);
    vecs[7]  = mk(1, 0, 32'h0,         0, 0, 64'h0,   1, 64'h10,  32'h0,         64'h0,   0, 0);
    vecs[8]  = mk(1, 1, 32'hC0DE_0010, 0, 0, 64'h0,   1, 64'h10,  32'hC0DE_0010, 64'h10,  1, 1);
    // stall collides with ack for PC 0x18
    vecs[9]  = mk(1, 1, 32'hC0DE_0014, 0, 0, 64'h0,   1, 64'h14,  32'hC0DE_0014, 64'h14,  1, 1);
    vecs[10] = mk(1, 1, 32'hC0DE_0018, 1, 0, 64'h0,   1, 64'h18,  32'hC0DE_0014, 64'h14,  1, 1);
    vecs[11] = mk(1, 0, 32'h0,         1, 0, 64'h0,   0, 64'h0,   32'hC0DE_0014, 64'h14,  1, 1);
    vecs[12] = mk(1, 0, 32'h0,         1, 0, 64'h0,   0, 64'h0,   32'hC0DE_0014, 64'h14,  1, 1);
    vecs[13] = mk(1, 0, 32'h0,         1, 0, 64'h0,   0, 64'h0,   32'hC0DE_0014, 64'h14,  1, 1);
    vecs[14] = mk(1, 0, 32'h0,         0, 0, 64'h0,   0, 64'h0,   32'hC0DE_0018, 64'h18,  1, 1);
    vecs[15] = mk(1, 1, 32'hC0DE_001C, 0, 0, 64'h0,   1, 64'h1C,  32'hC0DE_001C, 64'h1C,  1, 1);
    // redirect while stalled with an outstanding request
    vecs[16] = mk(1, 0, 32'h0,         1, 0, 64'h0,   1, 64'h20,  32'hC0DE_001C, 64'h1C,  1, 1);
    vecs[17] = mk(1, 0, 32'h0,         1, 1, 64'h100, 1, 64'h20,  32'h0,         64'h0,   0, 0);
    vecs[18] = mk(1, 0, 32'h0,         0, 0, 64'h0,   1, 64'h20,  32'h0,         64'h0,   0, 0);
    vecs[19] = mk(1, 1, 32'hDEAD_BEEF, 0, 0, 64'h0,   1, 64'h20,  32'h0,         64'h0,   0, 0);
    vecs[20] = mk(1, 1, 32'hC0DE_0100, 0, 0, 64'h0,   1, 64'h100, 32'hC0DE_0100, 64'h100, 1, 1);
    // redirect with same-cycle ack to an unaligned target near the top, then wrap
    vecs[21] = mk(1, 1, 32'hBADC_0DE0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 64'h104, 32'h0, 64'h0, 0, 0);
    vecs[22] = mk(1, 1, 32'hC0DE_FFFC, 0, 0, 64'h0,   1, TOP,     32'hC0DE_FFFC, TOP,     1, 1);
    vecs[23] = mk(1, 1, 32'hC0DE_0000, 0, 0, 64'h0,   1, 64'h0,   32'hC0DE_0000, 64'h0,   1, 1);
    // enter DROP, then reset with an ack in the reset cycle
    vecs[24] = mk(1, 0, 32'h0,         0, 1, 64'h200, 1, 64'h4,   32'h0,         64'h0,   0, 0);
    vecs[25] = mk(0, 1, 32'hDEAD_BEEF, 0, 0, 64'h0,   0, 64'h0,   32'h0,         64'h0,   0, 1);
    vecs[26] = mk(1, 0, 32'h0,         0, 0, 64'h0,   1, 64'h0,   32'h0,         64'h0,   0, 0);
    vecs[27] = mk(1, 1, 32'hC0DE_0000, 0, 0, 64'h0,   1, 64'h0,   32'hC0DE_0000, 64'h0,   1, 1);
    // redirect out of HOLD discards the skid entry
    vecs[28] = mk(1, 1, 32'hC0DE_0004, 1, 0, 64'h0,   1, 64'h4,   32'hC0DE_0000, 64'h0,   1, 1);
    vecs[29] = mk(1, 0, 32'h0,         1, 1, 64'h40,  0, 64'h0,   32'h0,         64'h0,   0, 0);
    vecs[30] = mk(1, 1, 32'hC0DE_0040, 0, 0, 64'h0,   1, 64'h40,  32'hC0DE_0040, 64'h40,  1, 1);

    for (int i = 0; i < 31; i++) apply(vecs[i], i);

    // long reset with acks present, then zero-wait stream from RESET_PC
    for (int i = 0; i < 2; i++)
      apply(mk(0, 1, 32'hDEAD_BEEF, 0, 0, 64'h0, 0, 64'h0, 32'h0, 64'h0, 0, 1), 100 + i);
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] a;
      a = N'(4 * k);
      apply(mk(1, 1, word(a), 0, 0, 64'h0, 1, a, word(a), a, 1, 1), 110 + k);
    end

    // second redirect while in DROP replaces the stored target
    apply(mk(1, 0, 32'h0,         0, 1, 64'h300, 1, 64'h14, 32'h0, 64'h0, 0, 0), 120);
    apply(mk(1, 0, 32'h0,         0, 1, 64'h381, 1, 64'h14, 32'h0, 64'h0, 0, 0), 121);
    apply(mk(1, 1, 32'hDEAD_BEEF, 0, 0, 64'h0,   1, 64'h14, 32'h0, 64'h0, 0, 0), 122);
    apply(mk(1, 1, word(64'h380), 0, 0, 64'h0, 1, 64'h380, word(64'h380), 64'h380, 1, 1), 123);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
